reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Parametrised successor to the fixed 7-bit reset stretcher in the CPU top level.
- Accepts the async system reset, stretches it, then releases NUM_DOMAINS reset domains in a fixed order (e.g. bus/cache, TLB/CP0, core).
- Adds a software-requested reset with bus-quiesce handshake and timeout, and reports the cause of the last reset.
- Sits at the top level; all CPU-side blocks take their reset from rst_out.

Parameters:
- NUM_DOMAINS, 3, number of reset outputs; domain 0 releases first.
- STRETCH_CYCLES, 128, cycles from synchronized release to domain 0 deassert; must be >=1.
- STAGE_GAP, 4, extra cycles between successive domain releases; 0 releases all domains together.
- QUIESCE_TIMEOUT, 256, maximum cycles to wait for quiesce_ack; must be >=1.
- SYNC_STAGES, 2, depth of the reset-deassert synchronizer; must be >=2.
- WDT_CYCLES, 1048576, watchdog period (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high system reset
- soft_req  in  1  single-cycle software reset request (from CP0)
- quiesce_req  out  1  asks bus masters to drain; held until ack or timeout
- quiesce_ack  in  1  bus idle acknowledge
- wdt_kick  in  1  watchdog restart pulse; ignored without the optional feature
- rst_out  out  NUM_DOMAINS  active-high domain resets
- all_released  out  1  high once every rst_out bit is low
- last_cause  out  2  0=POR, 1=SOFT, 2=SOFT_FORCED (timeout), 3=WDT

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Assertion takes effect immediately; deassertion passes through the SYNC_STAGES synchronizer.
- Values while reset is high:
  - rst_out = all ones, quiesce_req = 0, all_released = 0, last_cause = 0.
  - State = ASSERT, count = 0, sync_rel = 0.
- Release timing: if reset falls before edge 0, sync_rel rises at edge SYNC_STAGES-1. Counting begins on the following edge.
- States: ASSERT, RELEASE, RUN, QUIESCE.
- ASSERT: rst_out all ones. When sync_rel=1, go to RELEASE with count = 0.
- RELEASE: count increments by 1 each cycle, saturating at the last release point. rst_out[i] clears, registered, on the edge where count reaches STRETCH_CYCLES-1 + i*STAGE_GAP. The state goes to RUN and all_released rises on the same edge that clears the last domain.
- Ordering: rst_out bits deassert in increasing index and never reassert individually.
- RUN:
  - soft_req=1: go to QUIESCE; quiesce_req=1 from the next edge; timeout counter = 0.
  - quiesce_ack is ignored in RUN.
- QUIESCE: the timeout counter increments each cycle.
  - quiesce_ack=1 on any cycle: go to ASSERT next edge, last_cause=1.
  - Counter reaching QUIESCE_TIMEOUT-1 without ack: same transition, last_cause=2.
  - Ack on the timeout cycle counts as ack (cause 1).
  - On entering ASSERT: quiesce_req=0, rst_out all ones, all_released=0 on the same edge.
- Soft reset path: ASSERT entered from QUIESCE or WDT skips the synchronizer and goes to RELEASE on the next edge.
- soft_req outside RUN is ignored and not queued.
- last_cause changes only on entry to ASSERT. It holds through the stretch so software can read it after release.
- Counter width: $clog2(max(STRETCH_CYCLES+(NUM_DOMAINS-1)*STAGE_GAP, QUIESCE_TIMEOUT)+1). No wrap is possible.
- Async reset asserted mid-sequence (any state) returns everything to reset values at once, including last_cause=0.

Optional Feature:
- Macro: RESET_SEQ_WDT_EN.
- When defined:
  - A watchdog counter runs only in RUN; it is cleared by wdt_kick and on leaving RUN.
  - On reaching WDT_CYCLES-1, go straight to ASSERT (no quiesce) with last_cause=3.
  - WDT expiry has priority over a same-cycle soft_req.
- When undefined: no watchdog logic; wdt_kick is unconnected internally; cause 3 is never produced.

Decomposition:
- Package reset_seq_pkg: typedef enum reset_state_t {ASSERT, RELEASE, RUN, QUIESCE}; typedef enum logic [1:0] reset_cause_t {POR, SOFT, SOFT_FORCED, WDT}.
- Sub-module reset_sync: SYNC_STAGES flop chain, asynchronous set, synchronous release. It produces sync_rel.

Test Plan:
- POR, defaults; reset falls before edge 0 -> rst_out[0] falls at edge 129, [1] at 133, [2] at 137; all_released rises at edge 137; last_cause=0.
- In RUN, soft_req pulse, quiesce_ack 10 cycles later -> quiesce_req high for 10 cycles, then rst_out=3'b111; domains release 128/132/136 cycles later; last_cause=1.
- soft_req with quiesce_ack held 0 -> quiesce_req drops after exactly 256 cycles, rst_out all ones, last_cause=2.
- Async reset raised mid-RELEASE and mid-QUIESCE -> immediate rst_out=all ones, quiesce_req=0, last_cause=0; a full POR sequence follows.
- STAGE_GAP=0, NUM_DOMAINS=4 -> all four bits fall on the same edge; soft_req during RELEASE has no effect.
- RESET_SEQ_WDT_EN, WDT_CYCLES=64: kick every 50 cycles -> no reset. Stop kicking -> reset 64 cycles after the last kick, last_cause=3. Expiry coinciding with soft_req -> cause 3, quiesce_req stays 0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: controller states and reset-cause encoding.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        RUN,
        QUIESCE
    } reset_state_t;

    typedef enum logic [1:0] {
        POR,
        SOFT,
        SOFT_FORCED,
        WDT
    } reset_cause_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Software-reset handshake between CP0 / bus masters and the reset sequencer.
interface reset_sequencer_if;
    logic soft_req;
    logic quiesce_req;
    logic quiesce_ack;
    logic wdt_kick;

    modport master (
        output soft_req,
        output quiesce_ack,
        output wdt_kick,
        input  quiesce_req
    );

    modport slave (
        input  soft_req,
        input  quiesce_ack,
        input  wdt_kick,
        output quiesce_req
    );
endinterface

// File: rtl/reset_sync.sv
// Reset-deassert synchronizer: asserts asynchronously, releases after SYNC_STAGES clock edges.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sync_rel
);
    logic [SYNC_STAGES-1:0] hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '1;
        end else begin
            hold_q <= {hold_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign sync_rel = ~hold_q[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Stretches the system reset and releases NUM_DOMAINS resets in order; handles software reset
// with bus quiesce. Optional watchdog enabled by defining RESET_SEQ_WDT_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS     = 3,
    parameter int STRETCH_CYCLES  = 128,
    parameter int STAGE_GAP       = 4,
    parameter int QUIESCE_TIMEOUT = 256,
    parameter int SYNC_STAGES     = 2,
    parameter int WDT_CYCLES      = 1048576
) (
    input  logic                   clk,
    input  logic                   reset,
    reset_sequencer_if.slave       ctl,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   all_released,
    output logic [1:0]             last_cause
);
    localparam int LAST_REL = STRETCH_CYCLES - 1 + (NUM_DOMAINS - 1) * STAGE_GAP;
    localparam int CW = $clog2(max2(STRETCH_CYCLES + (NUM_DOMAINS - 1) * STAGE_GAP,
                                    QUIESCE_TIMEOUT) + 1);

    reset_state_t           state_q, state_d;
    logic [CW-1:0]          count_q, count_d, rel_count;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d, rel_hit;
    logic                   qreq_q, qreq_d;
    reset_cause_t           cause_q, cause_d;
    logic                   sync_rel;
    logic                   wdt_expire;

    reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (reset),
        .sync_rel (sync_rel)
    );

    // Count value as it will stand after this edge; zero on the ASSERT->RELEASE edge.
    assign rel_count = (state_q != RELEASE)        ? '0 :
                       (count_q == CW'(LAST_REL))  ? count_q :
                                                     count_q + CW'(1);

    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rel
        assign rel_hit[gi] = (rel_count >= CW'(STRETCH_CYCLES - 1 + gi * STAGE_GAP));
    end

`ifdef RESET_SEQ_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);
    logic [WW-1:0] wdt_q, wdt_d;

    assign wdt_expire = (state_q == RUN) && !ctl.wdt_kick && (wdt_q == WW'(WDT_CYCLES - 1));
    assign wdt_d = (state_q == RUN && state_d == RUN && !ctl.wdt_kick) ? wdt_q + WW'(1) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    assign wdt_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rst_d   = rst_q;
        qreq_d  = qreq_q;
        cause_d = cause_q;
        case (state_q)
            ASSERT: begin
                rst_d = '1;
                if (sync_rel) begin
                    count_d = '0;
                    rst_d   = ~rel_hit;
                    state_d = (&rel_hit) ? RUN : RELEASE;
                end
            end
            RELEASE: begin
                count_d = rel_count;
                rst_d   = rst_q & ~rel_hit;
                if (&rel_hit) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wdt_expire) begin
                    state_d = ASSERT;
                    rst_d   = '1;
                    count_d = '0;
                    cause_d = WDT;
                end else if (ctl.soft_req) begin
                    state_d = QUIESCE;
                    qreq_d  = 1'b1;
                    count_d = '0;
                end
            end
            QUIESCE: begin
                count_d = count_q + CW'(1);
                // An ack on the timeout cycle still counts as a clean quiesce.
                if (ctl.quiesce_ack || count_q == CW'(QUIESCE_TIMEOUT - 1)) begin
                    state_d = ASSERT;
                    qreq_d  = 1'b0;
                    rst_d   = '1;
                    count_d = '0;
                    cause_d = ctl.quiesce_ack ? SOFT : SOFT_FORCED;
                end
            end
            default: state_d = ASSERT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ASSERT;
            count_q <= '0;
            rst_q   <= '1;
            qreq_q  <= 1'b0;
            cause_q <= POR;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rst_q   <= rst_d;
            qreq_q  <= qreq_d;
            cause_q <= cause_d;
        end
    end

    assign rst_out         = rst_q;
    assign all_released    = ~|rst_q;
    assign last_cause      = cause_q;
    assign ctl.quiesce_req = qreq_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized self-checking bench for reset_sequencer against an edge-schedule reference model.
module tb_reset_sequencer;
    localparam int S  = 128;
    localparam int G  = 4;
    localparam int N  = 3;
    localparam int SY = 2;
    localparam int T  = 256;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reset_sequencer_if c1();
    reset_sequencer_if c2();
    logic [2:0] rst1;
    logic       ar1;
    logic [1:0] lc1;
    logic [3:0] rst2;
    logic       ar2;
    logic [1:0] lc2;

    reset_sequencer #(
        .NUM_DOMAINS(N), .STRETCH_CYCLES(S), .STAGE_GAP(G),
        .QUIESCE_TIMEOUT(T), .SYNC_STAGES(SY), .WDT_CYCLES(1048576)
    ) dut1 (
        .clk(clk), .reset(reset), .ctl(c1),
        .rst_out(rst1), .all_released(ar1), .last_cause(lc1)
    );

    reset_sequencer #(
        .NUM_DOMAINS(4), .STRETCH_CYCLES(16), .STAGE_GAP(0)
    ) dut2 (
        .clk(clk), .reset(reset), .ctl(c2),
        .rst_out(rst2), .all_released(ar2), .last_cause(lc2)
    );

`ifdef RESET_SEQ_WDT_EN
    reset_sequencer_if c3();
    logic [2:0] rst3;
    logic       ar3;
    logic [1:0] lc3;

    reset_sequencer #(
        .NUM_DOMAINS(3), .STRETCH_CYCLES(16), .STAGE_GAP(4), .WDT_CYCLES(64)
    ) dut3 (
        .clk(clk), .reset(reset), .ctl(c3),
        .rst_out(rst3), .all_released(ar3), .last_cause(lc3)
    );
`endif

    // Reference model for dut1: edge numbers of ASSERT entry, domain-0 release and quiesce window.
    bit         m_hold = 1'b1;
    int         m_base, m_assert, m_rel0, m_qs, m_qe, m2_rel, m3_rel;
    logic [1:0] m_cause = 2'd0;
    logic [1:0] m_cause_old = 2'd0;

    function automatic logic [6:0] model1(input int c);
        logic [2:0] r;
        logic       q;
        logic [1:0] k;
        if (m_hold) return 7'b111_0_0_00;
        for (int i = 0; i < N; i++) r[i] = (c >= m_assert) && (c < m_rel0 + i * G);
        q = (c >= m_qs) && (c < m_qe);
        k = (c >= m_assert) ? m_cause : m_cause_old;
        return {r, q, (r == 3'b000), k};
    endfunction

    function automatic logic [6:0] obs1();
        return {rst1, c1.quiesce_req, ar1, lc1};
    endfunction

    task automatic por_release();
        @(negedge clk);
        reset       = 1'b0;
        m_hold      = 1'b0;
        m_base      = cyc + 1;
        m_assert    = m_base;
        m_rel0      = m_base + SY + S - 1;
        m_qs        = 0;
        m_qe        = 0;
        m_cause     = 2'd0;
        m_cause_old = 2'd0;
        m2_rel      = m_base + SY + 16 - 1;
        m3_rel      = m_base + SY + 16 - 1 + 2 * 4;
    endtask

    task automatic soft_model(input int e, input int d);
        m_cause_old = m_cause;
        m_cause     = (d <= T) ? 2'd1 : 2'd2;
        m_qs        = e;
        m_qe        = e + ((d <= T) ? d : T);
        m_assert    = m_qe;
        m_rel0      = m_qe + S;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs1() !== 7'b111_0_0_00) begin
            errors++;
            $display("FAIL reset_hold dut1 got=%b exp=%b", obs1(), 7'b111_0_0_00);
        end
        checks++;
        if ({rst2, ar2, lc2} !== 7'b1111_0_00) begin
            errors++;
            $display("FAIL reset_hold dut2 got=%b exp=%b", {rst2, ar2, lc2}, 7'b1111_0_00);
        end
        por_release();
        while (cyc < m_rel0 + (N - 1) * G + 3) begin
            @(negedge clk);
            checks++;
            if (obs1() !== model1(cyc)) begin
                errors++;
                $display("FAIL por cyc=%0d got=%b exp=%b", cyc - m_base, obs1(), model1(cyc));
            end
        end
        $display("por: edge0=%0d domain0 release edge %0d (relative %0d)", m_base, m_rel0, m_rel0 - m_base);
    endtask

    task automatic test_soft(input int d, input string tag);
        int e;
        int stray;
        @(negedge clk);
        checks++;
        if (obs1() !== model1(cyc)) begin
            errors++;
            $display("FAIL %s pre cyc=%0d got=%b exp=%b", tag, cyc, obs1(), model1(cyc));
        end
        c1.quiesce_ack = 1'b1;    // ack while in RUN must be ignored
        @(negedge clk);
        c1.quiesce_ack = 1'b0;
        c1.soft_req    = 1'b1;
        e = cyc + 1;
        soft_model(e, d);
        stray = m_assert + $urandom_range(5, S - 10);
        while (cyc < m_rel0 + (N - 1) * G + 3) begin
            @(negedge clk);
            checks++;
            if (obs1() !== model1(cyc)) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc - e, obs1(), model1(cyc));
            end
            c1.soft_req    = (cyc + 1 == stray);
            c1.quiesce_ack = (d <= T) && (cyc + 1 == e + d);
        end
        c1.soft_req    = 1'b0;
        c1.quiesce_ack = 1'b0;
        $display("%s: ack_delay=%0d quiesce_cycles=%0d cause=%0d", tag, d, m_qe - m_qs, m_cause);
    endtask

    task automatic test_async(input bit mid_quiesce);
        int e;
        int d;
        d = mid_quiesce ? T + 100 : 5;
        @(negedge clk);
        c1.soft_req = 1'b1;
        e = cyc + 1;
        soft_model(e, d);
        while (cyc < e + (mid_quiesce ? 50 : 5 + 40)) begin
            @(negedge clk);
            checks++;
            if (obs1() !== model1(cyc)) begin
                errors++;
                $display("FAIL async_pre cyc=%0d got=%b exp=%b", cyc - e, obs1(), model1(cyc));
            end
            c1.soft_req    = 1'b0;
            c1.quiesce_ack = !mid_quiesce && (cyc + 1 == e + d);
        end
        c1.quiesce_ack = 1'b0;
        reset  = 1'b1;
        m_hold = 1'b1;
        #1;
        checks++;
        if (obs1() !== 7'b111_0_0_00) begin
            errors++;
            $display("FAIL async_immediate got=%b exp=%b", obs1(), 7'b111_0_0_00);
        end
        por_release();
        while (cyc < m_rel0 + (N - 1) * G + 3) begin
            @(negedge clk);
            checks++;
            if (obs1() !== model1(cyc)) begin
                errors++;
                $display("FAIL async_por cyc=%0d got=%b exp=%b", cyc - m_base, obs1(), model1(cyc));
            end
        end
        $display("async reset during %s: immediate reset, POR release edge %0d", mid_quiesce ? "QUIESCE" : "RELEASE", m_rel0 - m_base);
    endtask

    task automatic test_gap0();
        int         stray;
        logic [3:0] exp;
        @(negedge clk);
        reset  = 1'b1;
        m_hold = 1'b1;
        #1;
        checks++;
        if (rst2 !== 4'hF) begin
            errors++;
            $display("FAIL gap0_reset got=%h exp=%h", rst2, 4'hF);
        end
        por_release();
        stray = m_base + $urandom_range(3, 12);
        while (cyc < m2_rel + 5) begin
            @(negedge clk);
            exp = (cyc < m2_rel) ? 4'hF : 4'h0;
            checks++;
            if ({rst2, ar2, lc2} !== {exp, (exp == 4'h0), 2'b00}) begin
                errors++;
                $display("FAIL gap0 cyc=%0d got=%b exp=%b", cyc - m_base, {rst2, ar2, lc2}, {exp, (exp == 4'h0), 2'b00});
            end
            c2.soft_req = (cyc + 1 == stray);
        end
        c2.soft_req = 1'b0;
        $display("gap0: 4 domains released together at edge %0d, soft_req at edge %0d ignored", m2_rel - m_base, stray - m_base);
    endtask

`ifdef RESET_SEQ_WDT_EN
    task automatic test_wdt();
        int r;
        int k;
        int a;
        int r2;
        @(negedge clk);
        reset  = 1'b1;
        m_hold = 1'b1;
        por_release();
        r = m3_rel;
        while (cyc < r) @(negedge clk);
        k = r;
        while (cyc < r + 200) begin
            checks++;
            if ({rst3, ar3, lc3, c3.quiesce_req} !== 7'b000_1_00_0) begin
                errors++;
                $display("FAIL wdt_kicked cyc=%0d got=%b exp=%b", cyc - r, {rst3, ar3, lc3, c3.quiesce_req}, 7'b000_1_00_0);
            end
            c3.wdt_kick = ((cyc + 1 - r) % 50 == 0);
            if (c3.wdt_kick) k = cyc + 1;
            @(negedge clk);
        end
        c3.wdt_kick = 1'b0;
        while (cyc < k + 63) begin
            @(negedge clk);
            checks++;
            if (rst3 !== 3'b000) begin
                errors++;
                $display("FAIL wdt_early cyc=%0d got=%b exp=%b", cyc - k, rst3, 3'b000);
            end
        end
        @(negedge clk);
        checks++;
        if ({rst3, lc3, c3.quiesce_req} !== 6'b111_11_0) begin
            errors++;
            $display("FAIL wdt_expire got=%b exp=%b", {rst3, lc3, c3.quiesce_req}, 6'b111_11_0);
        end
        a  = k + 64;
        r2 = a + 16 + 2 * 4;
        while (cyc < r2 + 63) begin
            @(negedge clk);
            if (cyc >= r2) begin
                checks++;
                if ({rst3, lc3} !== 5'b000_11) begin
                    errors++;
                    $display("FAIL wdt_rerun cyc=%0d got=%b exp=%b", cyc - r2, {rst3, lc3}, 5'b000_11);
                end
            end
        end
        c3.soft_req = 1'b1;
        @(negedge clk);
        c3.soft_req = 1'b0;
        repeat (6) begin
            checks++;
            if ({rst3, lc3, c3.quiesce_req} !== 6'b111_11_0) begin
                errors++;
                $display("FAIL wdt_vs_soft cyc=%0d got=%b exp=%b", cyc - r2, {rst3, lc3, c3.quiesce_req}, 6'b111_11_0);
            end
            @(negedge clk);
        end
        $display("wdt: last kick edge %0d, expiry edge %0d, expiry with soft_req gives cause 3", k, a);
    endtask
`endif

    initial begin
        c1.soft_req = 1'b0; c1.quiesce_ack = 1'b0; c1.wdt_kick = 1'b0;
        c2.soft_req = 1'b0; c2.quiesce_ack = 1'b0; c2.wdt_kick = 1'b0;
`ifdef RESET_SEQ_WDT_EN
        c3.soft_req = 1'b0; c3.quiesce_ack = 1'b0; c3.wdt_kick = 1'b0;
`endif
        test_reset();
        test_soft(10, "soft_ack10");
        test_soft(T, "soft_ack_on_timeout");
        test_soft(T + 1 + $urandom_range(0, 40), "soft_timeout");
        test_soft($urandom_range(1, 300), "soft_rand_a");
        test_soft($urandom_range(1, 300), "soft_rand_b");
        test_async(1'b0);
        test_async(1'b1);
        test_gap0();
`ifdef RESET_SEQ_WDT_EN
        test_wdt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL timeout at cyc=%0d", cyc);
        $fatal(1, "simulation time limit reached");
    end
endmodule
